// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pattern generator.
//   H_ACTIVE / V_ACTIVE : visible raster size in pixels
//   BAR_W               : width of one colour bar
//   mode_e              : pattern selection (BARS, CHECKER, GRADIENT, BOX)
//   BAR_* / bar_color() : 1-bit-per-channel colours of the eight bars
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int BAR_W    = 80;

  typedef enum logic [1:0] {
    BARS     = 2'd0,
    CHECKER  = 2'd1,
    GRADIENT = 2'd2,
    BOX      = 2'd3
  } mode_e;

  // One bit per channel; expanded to the full channel width by the user.
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } bar_rgb_t;

  localparam bar_rgb_t BAR_WHITE   = 3'b111;
  localparam bar_rgb_t BAR_YELLOW  = 3'b110;
  localparam bar_rgb_t BAR_CYAN    = 3'b011;
  localparam bar_rgb_t BAR_GREEN   = 3'b010;
  localparam bar_rgb_t BAR_MAGENTA = 3'b101;
  localparam bar_rgb_t BAR_RED     = 3'b100;
  localparam bar_rgb_t BAR_BLUE    = 3'b001;
  localparam bar_rgb_t BAR_BLACK   = 3'b000;

  // Colour of bar number idx, counted from the left edge.
  function automatic bar_rgb_t bar_color(input logic [2:0] idx);
    bar_color = BAR_BLACK;
    case (idx)
      3'd0: bar_color = BAR_WHITE;
      3'd1: bar_color = BAR_YELLOW;
      3'd2: bar_color = BAR_CYAN;
      3'd3: bar_color = BAR_GREEN;
      3'd4: bar_color = BAR_MAGENTA;
      3'd5: bar_color = BAR_RED;
      3'd6: bar_color = BAR_BLUE;
      default: bar_color = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Video bus between a VGA timing controller (master) and the pattern
// generator (slave).
//   h_sync_in, v_sync_in   : controller syncs, active-low
//   display_enable         : high in the visible region
//   x_count, y_count       : current pixel coordinates
//   h_sync, v_sync         : syncs delayed to line up with the colour
//   red, green, blue       : pixel colour, COLOR_W bits per channel
//   mode, frame_count      : active pattern and frames since reset
interface vga_pattern_gen_if #(parameter int COLOR_W = 4);

  logic               h_sync_in;
  logic               v_sync_in;
  logic               display_enable;
  logic [9:0]         x_count;
  logic [9:0]         y_count;
  logic               h_sync;
  logic               v_sync;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;
  logic [1:0]         mode;
  logic [7:0]         frame_count;

  modport master (
    output h_sync_in, v_sync_in, display_enable, x_count, y_count,
    input  h_sync, v_sync, red, green, blue, mode, frame_count
  );

  modport slave (
    input  h_sync_in, v_sync_in, display_enable, x_count, y_count,
    output h_sync, v_sync, red, green, blue, mode, frame_count
  );

endinterface

// File: rtl/vga_btn_sync.sv
// Two-flop synchroniser for an asynchronous pushbutton plus a one-cycle
// rising-edge pulse on the synchronised level.
//   clk       : pixel clock
//   reset     : asynchronous, active-low
//   btn_async : raw button level
//   btn_rise  : high for one cycle after each synchronised 0->1 transition
module vga_btn_sync (
  input  logic clk,
  input  logic reset,
  input  logic btn_async,
  output logic btn_rise
);

  logic btn_meta;
  logic btn_sync;
  logic btn_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its source, giving a true shift chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      btn_meta <= btn_async;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
    end
  end

  assign btn_rise = btn_sync & ~btn_prev;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator. Picks a colour for each incoming pixel from
// one of four patterns, blanks it outside the visible region, and re-times
// syncs and colour through a matched two-stage pipeline.
//   clk      : 25 MHz pixel clock
//   reset    : asynchronous, active-low
//   mode_btn : asynchronous pushbutton; each press advances the pattern at
//              the next frame start
//   vga      : video bus (slave side), see vga_pattern_gen_if
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int COLOR_W  = 4,
  parameter int BOX_SIZE = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode_btn,
  vga_pattern_gen_if.slave vga
);

  localparam logic [9:0]         BOX_X_MAX = 10'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0]         BOX_Y_MAX = 10'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0]        BOX_SPAN  = 11'(BOX_SIZE);
  localparam logic [COLOR_W-1:0] C_FULL    = '1;
  localparam logic [COLOR_W-1:0] C_HALF    = COLOR_W'(1 << (COLOR_W - 1));

  // ---------------------------------------------------------------------
  // Frame-rate control: frame counter, mode selection, bouncing box
  // ---------------------------------------------------------------------
  logic       btn_rise;
  logic       vs_prev;
  logic       frame_start;
  logic       pending;
  logic [1:0] mode_q;
  logic [7:0] frame_cnt;
  logic [9:0] box_x, box_y;
  logic [9:0] next_x, next_y;
  logic       dir_x, dir_y;   // 1 = moving towards larger coordinates

  vga_btn_sync u_btn_sync (
    .clk       (clk),
    .reset     (reset),
    .btn_async (mode_btn),
    .btn_rise  (btn_rise)
  );

  assign frame_start = vs_prev & ~vga.v_sync_in;
  assign next_x      = dir_x ? box_x + 10'd1 : box_x - 10'd1;
  assign next_y      = dir_y ? box_y + 10'd1 : box_y - 10'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_prev   <= 1'b1;
      pending   <= 1'b0;
      mode_q    <= BARS;
      frame_cnt <= 8'd0;
      box_x     <= 10'd0;
      box_y     <= 10'd0;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
    end else begin
      vs_prev <= vga.v_sync_in;
      // A press seen on the frame-start cycle itself survives the clear.
      pending <= btn_rise | (pending & ~frame_start);
      if (frame_start) begin
        frame_cnt <= frame_cnt + 8'd1;
        if (pending) mode_q <= mode_q + 2'd1;
        box_x <= next_x;
        box_y <= next_y;
        // Turn around on the same frame the box touches a wall.
        if (next_x == 10'd0 || next_x == BOX_X_MAX) dir_x <= ~dir_x;
        if (next_y == 10'd0 || next_y == BOX_Y_MAX) dir_y <= ~dir_y;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pattern selection (feeds pipeline stage 1)
  // ---------------------------------------------------------------------
  logic [COLOR_W-1:0] pix_r, pix_g, pix_b;
  bar_rgb_t           bar;
  logic               in_box;

  // NOTE: every output of this block is given a default first, so no
  // branch can leave a value unassigned and infer a latch.
  always_comb begin
    pix_r  = '0;
    pix_g  = '0;
    pix_b  = '0;
    bar    = bar_color(3'(vga.x_count / 10'(BAR_W)));
    in_box = ({1'b0, vga.x_count} >= {1'b0, box_x}) &&
             ({1'b0, vga.x_count} <  ({1'b0, box_x} + BOX_SPAN)) &&
             ({1'b0, vga.y_count} >= {1'b0, box_y}) &&
             ({1'b0, vga.y_count} <  ({1'b0, box_y} + BOX_SPAN));
    case (mode_e'(mode_q))
      BARS: begin
        if (vga.x_count < 10'(H_ACTIVE)) begin
          pix_r = {COLOR_W{bar.r}};
          pix_g = {COLOR_W{bar.g}};
          pix_b = {COLOR_W{bar.b}};
        end
      end
      CHECKER: begin
        if (vga.x_count[5] ^ vga.y_count[5]) begin
          pix_r = C_FULL;
          pix_g = C_FULL;
          pix_b = C_FULL;
        end
      end
      GRADIENT: begin
        pix_r = COLOR_W'(vga.x_count[9:6]);
        pix_g = COLOR_W'(vga.y_count[8:5]);
        pix_b = COLOR_W'(frame_cnt[3:0]);
      end
      BOX: begin
        if (in_box) begin
          pix_r = C_FULL;
          pix_g = C_FULL;
          pix_b = C_FULL;
        end else begin
          pix_b = C_HALF;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Stage 1 registers the chosen colour; stage 2 applies blanking. Syncs
  // ride the same two stages so nothing skews.
  // ---------------------------------------------------------------------
  logic [COLOR_W-1:0] s1_r, s1_g, s1_b;
  logic               s1_de, s1_hs, s1_vs;
  logic [COLOR_W-1:0] s2_r, s2_g, s2_b;
  logic               s2_hs, s2_vs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_r  <= '0;
      s1_g  <= '0;
      s1_b  <= '0;
      s1_de <= 1'b0;
      s1_hs <= 1'b1;
      s1_vs <= 1'b1;
      s2_r  <= '0;
      s2_g  <= '0;
      s2_b  <= '0;
      s2_hs <= 1'b1;
      s2_vs <= 1'b1;
    end else begin
      s1_r  <= pix_r;
      s1_g  <= pix_g;
      s1_b  <= pix_b;
      s1_de <= vga.display_enable;
      s1_hs <= vga.h_sync_in;
      s1_vs <= vga.v_sync_in;
      s2_r  <= s1_de ? s1_r : '0;
      s2_g  <= s1_de ? s1_g : '0;
      s2_b  <= s1_de ? s1_b : '0;
      s2_hs <= s1_hs;
      s2_vs <= s1_vs;
    end
  end

  assign vga.red         = s2_r;
  assign vga.green       = s2_g;
  assign vga.blue        = s2_b;
  assign vga.h_sync      = s2_hs;
  assign vga.v_sync      = s2_vs;
  assign vga.mode        = mode_q;
  assign vga.frame_count = frame_cnt;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen: directed steps plus randomized
// frames, compared against a frame-level behavioural model.
module tb_vga_pattern_gen;

  localparam int COLOR_W  = 4;
  localparam int BOX_SIZE = 32;

  logic clk      = 1'b0;
  logic reset    = 1'b0;
  logic mode_btn = 1'b0;

  always #20 clk = ~clk;

  vga_pattern_gen_if #(.COLOR_W(COLOR_W)) vga ();

  vga_pattern_gen #(.COLOR_W(COLOR_W), .BOX_SIZE(BOX_SIZE)) dut (
    .clk      (clk),
    .reset    (reset),
    .mode_btn (mode_btn),
    .vga      (vga)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } out_t;

  out_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state: frames since reset, pattern, pending press, history.
  int m_frames;
  int m_mode;
  bit m_pending;
  bit m_vs_prev;
  bit b1, b2, b3;   // button level driven 1, 2 and 3 steps ago

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Position along one axis after n wall-to-wall moves of 1 px: a triangle
  // wave between 0 and lim.
  function automatic int tri_pos(input int n, input int lim);
    int p;
    p = n % (2 * lim);
    return (p <= lim) ? p : 2 * lim - p;
  endfunction

  function automatic logic [11:0] ref_pixel(input bit de, input int x, input int y);
    logic [11:0] bars [8];
    int bx, by;
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    if (!de) return 12'h000;
    bx = tri_pos(m_frames, 640 - BOX_SIZE);
    by = tri_pos(m_frames, 480 - BOX_SIZE);
    case (m_mode)
      0: return (x >= 640) ? 12'h000 : bars[x / 80];
      1: return ((((x / 32) + (y / 32)) % 2) == 1) ? 12'hFFF : 12'h000;
      2: return 12'(((x / 64) % 16) * 256 + ((y / 32) % 16) * 16 + (m_frames % 16));
      default: return (x >= bx && x < bx + BOX_SIZE && y >= by && y < by + BOX_SIZE)
                      ? 12'hFFF : 12'h008;
    endcase
  endfunction

  task automatic drive_idle();
    vga.h_sync_in      = 1'b1;
    vga.v_sync_in      = 1'b1;
    vga.display_enable = 1'b0;
    vga.x_count        = 10'd0;
    vga.y_count        = 10'd0;
    mode_btn           = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset     = 1'b1;
    m_frames  = 0;
    m_mode    = 0;
    m_pending = 1'b0;
    m_vs_prev = 1'b1;
    b1 = 1'b0; b2 = 1'b0; b3 = 1'b0;
    exp_q.delete();
    exp_q.push_back('{hs: 1'b1, vs: 1'b1, rgb: 12'h000});
    exp_q.push_back('{hs: 1'b1, vs: 1'b1, rgb: 12'h000});
  endtask

  // One pixel clock: check what is due, drive new inputs, advance model.
  task automatic step(input bit hs, input bit vs, input bit de,
                      input int x, input int y, input bit btn);
    out_t e;
    bit   fs, rise;
    @(negedge clk);
    check("mode", 32'(vga.mode), m_mode);
    check("frame_count", 32'(vga.frame_count), m_frames % 256);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("h_sync", 32'(vga.h_sync), 32'(e.hs));
      check("v_sync", 32'(vga.v_sync), 32'(e.vs));
      check("rgb", 32'({vga.red, vga.green, vga.blue}), 32'(e.rgb));
    end
    vga.h_sync_in      = hs;
    vga.v_sync_in      = vs;
    vga.display_enable = de;
    vga.x_count        = 10'(x);
    vga.y_count        = 10'(y);
    mode_btn           = btn;
    e.hs  = hs;
    e.vs  = vs;
    e.rgb = ref_pixel(de, x, y);
    exp_q.push_back(e);
    fs        = m_vs_prev && !vs;
    m_vs_prev = vs;
    rise      = b2 && !b3;
    b3 = b2; b2 = b1; b1 = btn;
    if (fs) begin
      if (m_pending) m_mode = (m_mode + 1) % 4;
      m_frames++;
    end
    m_pending = rise || (m_pending && !fs);
  endtask

  task automatic idle_step();
    step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  // A compressed frame: one v_sync low cycle, then len random pixels.
  task automatic frame(input int len, input bit rnd_btn);
    bit hs, de, btn;
    int x, y;
    btn = rnd_btn ? 1'($urandom_range(0, 1)) : 1'b0;
    step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, 0, btn);
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        x = tri_pos(m_frames, 640 - BOX_SIZE) + int'($urandom_range(0, 40)) - 4;
        y = tri_pos(m_frames, 480 - BOX_SIZE) + int'($urandom_range(0, 40)) - 4;
        if (x < 0) x = 0;
        if (y < 0) y = 0;
      end else begin
        x = int'($urandom_range(0, 1023));
        y = int'($urandom_range(0, 1023));
      end
      hs  = ($urandom_range(0, 7) != 0);
      de  = ($urandom_range(0, 3) != 0);
      btn = rnd_btn ? 1'($urandom_range(0, 1)) : 1'b0;
      step(hs, 1'b1, de, x, y, btn);
    end
  endtask

  task automatic check_rgb(input string tag, input logic [11:0] exp);
    check(tag, 32'({vga.red, vga.green, vga.blue}), 32'(exp));
  endtask

  initial begin
    // Reset held low.
    drive_idle();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_h_sync", 32'(vga.h_sync), 32'd1);
    check("rst_v_sync", 32'(vga.v_sync), 32'd1);
    check_rgb("rst_rgb", 12'h000);
    check("rst_mode", 32'(vga.mode), 32'd0);
    check("rst_frame_count", 32'(vga.frame_count), 32'd0);

    release_reset();
    idle_step();
    idle_step();
    check("rel_h_sync", 32'(vga.h_sync), 32'd1);
    check("rel_v_sync", 32'(vga.v_sync), 32'd1);
    check_rgb("rel_rgb", 12'h000);

    // Colour bars: yellow at x = 85, black beyond the visible width.
    step(1'b1, 1'b1, 1'b1, 85, 10, 1'b0);
    step(1'b1, 1'b1, 1'b1, 700, 10, 1'b0);
    step(1'b1, 1'b1, 1'b1, 300, 10, 1'b0);
    check_rgb("bars_x85_yellow", 12'hFF0);
    idle_step();
    check_rgb("bars_x700_black", 12'h000);

    // Sync latency and blanking with display_enable low.
    step(1'b0, 1'b0, 1'b0, 10, 10, 1'b0);
    idle_step();
    check("h_sync_not_early", 32'(vga.h_sync), 32'd1);
    check("v_sync_not_early", 32'(vga.v_sync), 32'd1);
    idle_step();
    check("h_sync_at_n2", 32'(vga.h_sync), 32'd0);
    check("v_sync_at_n2", 32'(vga.v_sync), 32'd0);
    check_rgb("blank_de0", 12'h000);

    // Random frames with random button activity across all modes.
    repeat (40) frame(int'($urandom_range(2, 8)), 1'b1);

    // Reset asserted mid-frame takes effect immediately.
    step(1'b0, 1'b1, 1'b1, 5, 100, 1'b0);
    step(1'b0, 1'b1, 1'b1, 5, 100, 1'b0);
    step(1'b0, 1'b1, 1'b1, 5, 100, 1'b0);
    #5 reset = 1'b0;
    #1;
    check("midrst_h_sync", 32'(vga.h_sync), 32'd1);
    check("midrst_v_sync", 32'(vga.v_sync), 32'd1);
    check_rgb("midrst_rgb", 12'h000);
    check("midrst_mode", 32'(vga.mode), 32'd0);
    check("midrst_frame_count", 32'(vga.frame_count), 32'd0);
    drive_idle();
    repeat (2) @(negedge clk);
    release_reset();

    // Three presses inside one frame give a single increment.
    repeat (3) begin
      step(1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    end
    repeat (3) idle_step();
    check("mode_held_midframe", 32'(vga.mode), 32'd0);
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    idle_step();
    check("press_x3_one_incr", 32'(vga.mode), 32'd1);
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    idle_step();
    check("no_extra_incr", 32'(vga.mode), 32'd1);

    // Press whose edge lands on the frame-start cycle is deferred.
    step(1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    idle_step();
    check("edge_on_fs_deferred", 32'(vga.mode), 32'd1);
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    idle_step();
    check("edge_on_fs_applied", 32'(vga.mode), 32'd2);

    // One more press to reach the box pattern.
    step(1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    idle_step();
    check("mode_box", 32'(vga.mode), 32'd3);

    // Run the box to the right wall, watching the frame counter wrap.
    while (m_frames < 608) begin
      frame(int'($urandom_range(2, 6)), 1'b0);
      if (m_frames == 255) check("fc_255", 32'(vga.frame_count), 32'd255);
      if (m_frames == 256) check("fc_wrap_256", 32'(vga.frame_count), 32'd0);
      if (m_frames == 512) check("fc_wrap_512", 32'(vga.frame_count), 32'd0);
    end

    // 608 moves: box at (608, 288).
    step(1'b1, 1'b1, 1'b1, 608, 288, 1'b0);
    step(1'b1, 1'b1, 1'b1, 607, 288, 1'b0);
    step(1'b1, 1'b1, 1'b1, 639, 319, 1'b0);
    check_rgb("box608_left_edge_in", 12'hFFF);
    step(1'b1, 1'b1, 1'b1, 640, 319, 1'b0);
    check_rgb("box608_left_out", 12'h008);
    idle_step();
    check_rgb("box608_corner_in", 12'hFFF);
    idle_step();
    check_rgb("box608_right_out", 12'h008);

    // Next move reverses: box at (607, 287).
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 607, 287, 1'b0);
    step(1'b1, 1'b1, 1'b1, 639, 287, 1'b0);
    idle_step();
    check_rgb("box607_edge_in", 12'hFFF);
    idle_step();
    check_rgb("box607_right_out", 12'h008);
    check("fc_after_609", 32'(vga.frame_count), 32'd97);

    idle_step();
    idle_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
